// File: rtl/game_sched_pkg.sv
// Shared types and helpers for the dino runner run-time controller.
package game_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef logic [3:0] cfg_t;

    localparam cfg_t LEVEL_MAX = 4'd15;

    // Clamp a 5-bit sum to a 4-bit ceiling.
    function automatic cfg_t sat_cfg(input logic [4:0] v, input cfg_t lim);
        return (v > {1'b0, lim}) ? lim : v[3:0];
    endfunction

endpackage

// File: rtl/game_sched_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, debounced
// level and a one-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 65536
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic          rise_q, rise_d;

    // Flip the debounced level on the DEB_CYCLES-th consecutive disagreeing
    // cycle; any agreeing cycle restarts the count.
    always_comb begin
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        rise_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d  = sync2_q;
                cnt_d  = '0;
                rise_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchronizer and debounce state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = deb_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/game_sched.sv
// Run-time controller for the dino runner core: debounces the buttons,
// sequences IDLE/RUN/PAUSE, counts frames into difficulty levels and drives
// the game's speed/accel configuration.
// Optional macro GAME_SCHED_ACCEL_RAMP_EN ramps cfg_accel with the level;
// when undefined cfg_accel stays at ACCEL_INIT (outside override).
module game_sched
    import game_sched_pkg::*;
#(
    parameter int FRAMES_PER_LEVEL = 600,
    parameter int SPEED_INIT       = 2,
    parameter int SPEED_MAX        = 15,
    parameter int ACCEL_INIT       = 4,
    parameter int DEB_CYCLES       = 65536
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jump_btn,
    input  logic       halt_btn,
    input  logic       vsync_in,
    input  logic       override_in,
    input  logic [3:0] speed_man,
    input  logic [3:0] accel_man,
    output logic       jump_out,
    output logic       halt_out,
    output logic [3:0] cfg_speed,
    output logic [3:0] cfg_accel,
    output logic [3:0] level
);

    localparam int FCW = $clog2(FRAMES_PER_LEVEL + 1);
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_LEVEL - 1);

    // Handshake-free block: events are single-cycle pulses, consumed on the
    // cycle they are high; no valid/ready back-pressure exists.
    logic jump_lvl, jump_evt, halt_evt;
    logic halt_lvl_unused;  // halt only acts on its press edge

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_jump_deb (
        .clk_i   (clock),
        .rst_i   (reset),
        .btn_i   (jump_btn),
        .level_o (jump_lvl),
        .rise_o  (jump_evt)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_halt_deb (
        .clk_i   (clock),
        .rst_i   (reset),
        .btn_i   (halt_btn),
        .level_o (halt_lvl_unused),
        .rise_o  (halt_evt)
    );

    state_e         state_q, state_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    cfg_t           level_q, level_d;
    logic           ov1_q, ov2_q;
    logic           vsync_prev_q;
    logic           frame_tick;
    logic           halt_q, halt_d;
    logic           jump_q, jump_d;
    cfg_t           speed_q, speed_d;
    cfg_t           accel_q, accel_d;
    cfg_t           ramp_speed, ramp_accel;

    // vsync is active-low; a frame starts on its falling edge.
    assign frame_tick = vsync_prev_q & ~vsync_in;

    // Next-state logic for the game sequencer and frame/level counters.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        level_d     = level_q;
        case (state_q)
            ST_IDLE: begin
                frame_cnt_d = '0;
                level_d     = '0;
                if (jump_evt) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Tick is counted even when halt moves us to PAUSE this cycle.
                if (frame_tick) begin
                    if (frame_cnt_q == FC_LAST) begin
                        frame_cnt_d = '0;
                        if (level_q != LEVEL_MAX) level_d = level_q + 4'd1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                    end
                end
                if (halt_evt) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                // Halt has priority over jump when both arrive together.
                if (halt_evt) begin
                    state_d = ST_RUN;
                end else if (jump_evt) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = '0;
                    level_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ramp values and next output register values.
    always_comb begin
        ramp_speed = sat_cfg(5'(SPEED_INIT) + {1'b0, level_q}, cfg_t'(SPEED_MAX));
`ifdef GAME_SCHED_ACCEL_RAMP_EN
        ramp_accel = sat_cfg(5'(ACCEL_INIT) + {2'b00, level_q[3:1]}, LEVEL_MAX);
`else
        ramp_accel = cfg_t'(ACCEL_INIT);
`endif
        halt_d  = (state_q != ST_RUN);
        jump_d  = (state_q == ST_RUN) && jump_lvl;
        speed_d = ov2_q ? speed_man : ramp_speed;
        accel_d = ov2_q ? accel_man : ramp_accel;
    end

    // State, counters, override synchronizer, vsync edge register, outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= '0;
            level_q      <= '0;
            ov1_q        <= 1'b0;
            ov2_q        <= 1'b0;
            vsync_prev_q <= 1'b1;
            halt_q       <= 1'b1;
            jump_q       <= 1'b0;
            speed_q      <= cfg_t'(SPEED_INIT);
            accel_q      <= cfg_t'(ACCEL_INIT);
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            level_q      <= level_d;
            ov1_q        <= override_in;
            ov2_q        <= ov1_q;
            vsync_prev_q <= vsync_in;
            halt_q       <= halt_d;
            jump_q       <= jump_d;
            speed_q      <= speed_d;
            accel_q      <= accel_d;
        end
    end

    assign halt_out  = halt_q;
    assign jump_out  = jump_q;
    assign cfg_speed = speed_q;
    assign cfg_accel = accel_q;
    assign level     = level_q;

endmodule

// File: doc/game_sched.md
Name: game_sched

Overview:
- Run-time controller for the dino runner game core. Sits between the chip pins and the game.
- Debounces the raw jump and halt buttons.
- Sequences the game through idle, run and pause states, and drives the game's halt and jump inputs.
- Ramps the game's speed configuration with elapsed frames. A strap input lets the pin-supplied manual speed/accel values override the ramp.

Parameters:
- FRAMES_PER_LEVEL, 600: frame ticks per difficulty level (10 s at 60 Hz); minimum 1.
- SPEED_INIT, 2: cfg_speed at level 0.
- SPEED_MAX, 15: saturation ceiling for cfg_speed.
- ACCEL_INIT, 4: base cfg_accel.
- DEB_CYCLES, 65536: consecutive stable cycles required to accept a button change; minimum 2.

Ports:
- clock  in  1  system clock (the VGA pixel clock)
- reset  in  1  synchronous, active-high
- jump_btn  in  1  raw async jump button
- halt_btn  in  1  raw async halt button
- vsync_in  in  1  game's active-low vsync (same clock domain)
- override_in  in  1  async strap; 1 selects the manual config
- speed_man  in  4  manual speed value
- accel_man  in  4  manual accel value
- jump_out  out  1  to game jump input
- halt_out  out  1  to game halt input
- cfg_speed  out  4  to game speed config
- cfg_accel  out  4  to game accel config
- level  out  4  current difficulty level (debug/LED)

Behaviour:
- Synchronizers: jump_btn, halt_btn and override_in each pass through a 2-flop synchronizer. vsync_in is not synchronized.
- Debounce:
  - Each button has a counter.
  - The debounced state flips on the DEB_CYCLES-th consecutive cycle in which the synchronized value differs from it.
  - Any agreeing cycle clears the counter.
  - Edge pulses (jump_evt, halt_evt) last one cycle, on the debounced rising edge only.
- frame_tick: one cycle on each falling edge of vsync_in, using a one-register edge detector.
- FSM states:
  - IDLE: halt_out=1, jump_out=0, frame_cnt=0, level=0. jump_evt → RUN. halt_evt is ignored.
  - RUN: halt_out=0, jump_out = debounced jump level.
    - halt_evt → PAUSE.
    - On frame_tick, frame_cnt increments. At FRAMES_PER_LEVEL-1 it wraps to 0 and level increments, saturating at 15.
  - PAUSE: halt_out=1, jump_out=0, frame_cnt and level frozen. halt_evt → RUN. jump_evt → IDLE, which resets frame_cnt and level.
- Simultaneous events:
  - In RUN or PAUSE, halt_evt beats jump_evt.
  - If frame_tick coincides with halt_evt in RUN, the tick is counted before the state moves to PAUSE.
- Ramp speed: compute SPEED_INIT + level in 5 bits, then saturate to SPEED_MAX.
- Outputs: registered, updating the cycle after the state, level or override change.
  - override_sync=1: cfg_speed=speed_man, cfg_accel=accel_man.
  - override_sync=0: cfg_speed = ramp speed, cfg_accel per the Optional Feature.
  - Level tracking continues regardless of override.
- Reset (any time, including mid-debounce or mid-run):
  - state=IDLE, halt_out=1, jump_out=0, cfg_speed=SPEED_INIT, cfg_accel=ACCEL_INIT, level=0.
  - frame_cnt=0, debounce counters=0, debounced states=0, synchronizers=0.

Optional Feature:
- Macro: GAME_SCHED_ACCEL_RAMP_EN.
- Defined: ramp cfg_accel = min(ACCEL_INIT + (level>>1), 15), computed in 5 bits then saturated.
- Undefined: ramp cfg_accel = ACCEL_INIT constant.
- Override behaviour is identical in both cases.

Decomposition:
- Package game_sched_pkg:
  - state enum {ST_IDLE, ST_RUN, ST_PAUSE}
  - cfg_t (4-bit logic) typedef
  - LEVEL_MAX=15 constant
- Sub-module btn_debounce (params DEB_CYCLES): 2-flop sync, counter, debounced level, rise pulse. Instantiated twice.

Test Plan (DEB_CYCLES=4, FRAMES_PER_LEVEL=3, SPEED_INIT=2, SPEED_MAX=5, ACCEL_INIT=4):
- Reset released, no input → halt_out=1, jump_out=0, cfg_speed=2, cfg_accel=4, level=0, state IDLE.
- jump_btn 0→1 held → debounced rise 2+4 cycles after the raw edge; next cycle state=RUN, halt_out=0. A 3-cycle jump glitch instead → no change.
- In RUN, 9 vsync falling edges → level=3, cfg_speed=5. 3 more → level=4, cfg_speed stays 5 (saturated).
- In RUN, halt press → PAUSE, halt_out=1. 6 vsync edges → level unchanged. Halt press → RUN. Jump press in PAUSE → IDLE, level=0, cfg_speed=2.
- override_in=1, speed_man=9, accel_man=1 → after sync, cfg_speed=9, cfg_accel=1 while level keeps counting. override_in=0 → ramp values return.
- Halt and jump debounced edges in the same cycle during RUN → PAUSE. Reset asserted mid-RUN → all outputs return to reset values next cycle.
- With GAME_SCHED_ACCEL_RAMP_EN defined, level=4 → cfg_accel=6. With it undefined → cfg_accel=4.
